// File: rtl/mem_bus_sched.sv
// Memory bus scheduler: arbitrates instruction fetch and data access onto a single
// memory-access stage, with round-robin fairness and a read-modify-write lock.
module mem_bus_sched #(
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic        clk_2,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic        data_lock,
    output logic        mem_en,
    output logic        mem_pc_data,
    output logic        mem_w_rd,
    output logic [15:0] mem_address,
    output logic        fetch_ack,
    output logic        data_ack,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        lock_pending_q, lock_pending_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_data;

    // Data wins if it is alone, if a locked RMW is pending, or if fetch won last time.
    assign grant_data = data_req &&
                        (!fetch_req || lock_pending_q || (last_owner_q == OWN_FETCH));

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        lock_pending_d = lock_pending_q;
        we_d           = we_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        case (state_q)
            IDLE: begin
                if (fetch_req || data_req) begin
                    state_d        = ACCESS;
                    owner_d        = grant_data ? OWN_DATA : OWN_FETCH;
                    cnt_d          = WAIT_LD;
                    lock_pending_d = 1'b0;
                    if (grant_data) begin
                        we_d   = data_we;
                        addr_d = data_addr;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d      = IDLE;
                last_owner_d = owner_q;
                if (owner_q == OWN_DATA) begin
                    lock_pending_d = data_lock;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_FETCH;
            last_owner_q   <= OWN_DATA;
            lock_pending_q <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 16'h0000;
            cnt_q          <= 4'd0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            lock_pending_q <= lock_pending_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them immediately.
    assign mem_en      = (state_q == ACCESS);
    assign mem_pc_data = mem_en && (owner_q == OWN_FETCH);
    assign mem_w_rd    = mem_en && (owner_q == OWN_DATA) && we_q;
    assign mem_address = addr_q;
    assign fetch_ack   = (state_q == DONE) && (owner_q == OWN_FETCH);
    assign data_ack    = (state_q == DONE) && (owner_q == OWN_DATA);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_sched.sv
// Directed bench for mem_bus_sched: three instances with WAIT_CYC = 0, 2 and 3.
module tb_mem_bus_sched;

    logic        clk_2;
    logic        rst         [3];
    logic        fetch_req   [3];
    logic        data_req    [3];
    logic        data_we     [3];
    logic [15:0] data_addr   [3];
    logic        data_lock   [3];
    logic        mem_en      [3];
    logic        mem_pc_data [3];
    logic        mem_w_rd    [3];
    logic [15:0] mem_address [3];
    logic        fetch_ack   [3];
    logic        data_ack    [3];
    logic        busy        [3];

    int vectors = 0;
    int miscompares = 0;

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    mem_bus_sched #(.WAIT_CYC(0)) u_w0 (
        .clk_2(clk_2), .rst(rst[0]), .fetch_req(fetch_req[0]), .data_req(data_req[0]),
        .data_we(data_we[0]), .data_addr(data_addr[0]), .data_lock(data_lock[0]),
        .mem_en(mem_en[0]), .mem_pc_data(mem_pc_data[0]), .mem_w_rd(mem_w_rd[0]),
        .mem_address(mem_address[0]), .fetch_ack(fetch_ack[0]), .data_ack(data_ack[0]),
        .busy(busy[0])
    );

    mem_bus_sched #(.WAIT_CYC(2)) u_w2 (
        .clk_2(clk_2), .rst(rst[1]), .fetch_req(fetch_req[1]), .data_req(data_req[1]),
        .data_we(data_we[1]), .data_addr(data_addr[1]), .data_lock(data_lock[1]),
        .mem_en(mem_en[1]), .mem_pc_data(mem_pc_data[1]), .mem_w_rd(mem_w_rd[1]),
        .mem_address(mem_address[1]), .fetch_ack(fetch_ack[1]), .data_ack(data_ack[1]),
        .busy(busy[1])
    );

    mem_bus_sched #(.WAIT_CYC(3)) u_w3 (
        .clk_2(clk_2), .rst(rst[2]), .fetch_req(fetch_req[2]), .data_req(data_req[2]),
        .data_we(data_we[2]), .data_addr(data_addr[2]), .data_lock(data_lock[2]),
        .mem_en(mem_en[2]), .mem_pc_data(mem_pc_data[2]), .mem_w_rd(mem_w_rd[2]),
        .mem_address(mem_address[2]), .fetch_ack(fetch_ack[2]), .data_ack(data_ack[2]),
        .busy(busy[2])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input int i, input string tag, input logic en, input logic pc,
                           input logic wr, input logic fa, input logic da, input logic bsy);
        check({tag, ".mem_en"},      {15'd0, mem_en[i]},      {15'd0, en});
        check({tag, ".mem_pc_data"}, {15'd0, mem_pc_data[i]}, {15'd0, pc});
        check({tag, ".mem_w_rd"},    {15'd0, mem_w_rd[i]},    {15'd0, wr});
        check({tag, ".fetch_ack"},   {15'd0, fetch_ack[i]},   {15'd0, fa});
        check({tag, ".data_ack"},    {15'd0, data_ack[i]},    {15'd0, da});
        check({tag, ".busy"},        {15'd0, busy[i]},        {15'd0, bsy});
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]       = 1'b1;
            fetch_req[i] = 1'b0;
            data_req[i]  = 1'b0;
            data_we[i]   = 1'b0;
            data_addr[i] = 16'h0000;
            data_lock[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_out(i, "reset", 0, 0, 0, 0, 0, 0);
            check("reset.mem_address", mem_address[i], 16'h0000);
        end
        tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // WAIT_CYC=0 fetch only: one ACCESS cycle, then the ack.
        fetch_req[0] = 1'b1;
        tick(); chk_out(0, "t1.access", 1, 1, 0, 0, 0, 1);
        tick(); chk_out(0, "t1.done",   0, 0, 0, 1, 0, 1);
        fetch_req[0] = 1'b0;
        tick(); chk_out(0, "t1.idle",   0, 0, 0, 0, 0, 0);

        // WAIT_CYC=2 data write; inputs change after grant and must be ignored.
        data_req[1]  = 1'b1;
        data_we[1]   = 1'b1;
        data_addr[1] = 16'h01FF;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out(1, "t2.access", 1, 0, 1, 0, 0, 1);
            check("t2.access.mem_address", mem_address[1], 16'h01FF);
            data_we[1]   = 1'b0;
            data_addr[1] = 16'h1234;
        end
        tick(); chk_out(1, "t2.done", 0, 0, 0, 0, 1, 1);
        check("t2.done.mem_address", mem_address[1], 16'h01FF);
        data_req[1] = 1'b0;
        tick(); chk_out(1, "t2.idle", 0, 0, 0, 0, 0, 0);

        // Fetch on the same instance leaves mem_address untouched.
        fetch_req[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out(1, "t2f.access", 1, 1, 0, 0, 0, 1);
            check("t2f.mem_address", mem_address[1], 16'h01FF);
        end
        tick(); chk_out(1, "t2f.done", 0, 0, 0, 1, 0, 1);
        fetch_req[1] = 1'b0;
        tick(); chk_out(1, "t2f.idle", 0, 0, 0, 0, 0, 0);

        // Continuous contention after reset: fetch, data, fetch, data.
        rst[0] = 1'b1;
        #1;
        rst[0] = 1'b0;
        fetch_req[0] = 1'b1;
        data_req[0]  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            logic own_data;
            own_data = g[0];
            tick(); chk_out(0, "t3.access", 1, !own_data, 0, 0, 0, 1);
            tick(); chk_out(0, "t3.done", 0, 0, 0, !own_data, own_data, 1);
            tick(); chk_out(0, "t3.idle", 0, 0, 0, 0, 0, 0);
        end
        fetch_req[0] = 1'b0;
        data_req[0]  = 1'b0;

        // Locked data access wins the next contention; the one after goes to fetch.
        rst[0] = 1'b1;
        #1;
        rst[0] = 1'b0;
        data_req[0]  = 1'b1;
        data_lock[0] = 1'b1;
        tick(); chk_out(0, "t4.access1", 1, 0, 0, 0, 0, 1);
        tick(); chk_out(0, "t4.done1",   0, 0, 0, 0, 1, 1);
        tick(); chk_out(0, "t4.idle1",   0, 0, 0, 0, 0, 0);
        fetch_req[0] = 1'b1;
        data_lock[0] = 1'b0;
        tick(); chk_out(0, "t4.access2", 1, 0, 0, 0, 0, 1);
        tick(); chk_out(0, "t4.done2",   0, 0, 0, 0, 1, 1);
        tick(); chk_out(0, "t4.idle2",   0, 0, 0, 0, 0, 0);
        tick(); chk_out(0, "t4.access3", 1, 1, 0, 0, 0, 1);
        tick(); chk_out(0, "t4.done3",   0, 0, 0, 1, 0, 1);
        fetch_req[0] = 1'b0;
        data_req[0]  = 1'b0;
        tick(); chk_out(0, "t4.idle3",   0, 0, 0, 0, 0, 0);

        // WAIT_CYC=3: reset in the second ACCESS cycle aborts without an ack.
        fetch_req[2] = 1'b1;
        tick(); chk_out(2, "t5.access1", 1, 1, 0, 0, 0, 1);
        tick(); chk_out(2, "t5.access2", 1, 1, 0, 0, 0, 1);
        #2;
        rst[2] = 1'b1;
        #1;
        chk_out(2, "t5.rst_async", 0, 0, 0, 0, 0, 0);
        tick(); chk_out(2, "t5.rst_held", 0, 0, 0, 0, 0, 0);
        rst[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(); chk_out(2, "t5.regrant", 1, 1, 0, 0, 0, 1);
        end
        tick(); chk_out(2, "t5.done", 0, 0, 0, 1, 0, 1);
        fetch_req[2] = 1'b0;
        tick(); chk_out(2, "t5.idle", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_sched.md
MEM_BUS_SCHED -- requirements
Module: mem_bus_sched

Interface
REQ-001 Parameter WAIT_CYC, default 0, extra access cycles added to each grant; legal range 0..15.
REQ-002 clk_2  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 fetch_req  input  1  instruction-fetch request; held high until fetch_ack.
REQ-005 data_req  input  1  data-access request; held high until data_ack.
REQ-006 data_we  input  1  data direction: 1 = write, 0 = read; sampled at grant.
REQ-007 data_addr  input  16  data address; sampled at grant.
REQ-008 data_lock  input  1  read-modify-write lock; sampled in DONE of a data access.
REQ-009 mem_en  output  1  access enable to memory-access stage.
REQ-010 mem_pc_data  output  1  address select: 1 = PC (fetch), 0 = data address.
REQ-011 mem_w_rd  output  1  direction to memory-access stage: 1 = write.
REQ-012 mem_address  output  16  latched data address.
REQ-013 fetch_ack  output  1  one-cycle fetch-complete pulse.
REQ-014 data_ack  output  1  one-cycle data-complete pulse.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; transitions occur only on the rising edge of clk_2.
REQ-017 IDLE, no request: remain in IDLE; mem_en = 0.
REQ-018 IDLE, request present: grant one requester, latch owner, data_we and data_addr, load wait counter with WAIT_CYC, go to ACCESS.
REQ-019 Arbitration when exactly one request is present: that requester wins.
REQ-020 Arbitration when both requests are present: round-robin against last_owner; the requester that did not win last wins.
REQ-021 Lock override: if lock_pending = 1, data wins whenever data_req = 1, regardless of round-robin.
REQ-022 lock_pending clears on the next grant.
REQ-023 ACCESS: mem_en = 1.
REQ-024 ACCESS, fetch owner: mem_pc_data = 1, mem_w_rd = 0.
REQ-025 ACCESS, data owner: mem_pc_data = 0, mem_w_rd = latched data_we, mem_address = latched data_addr.
REQ-026 ACCESS duration: exactly WAIT_CYC + 1 cycles; counter decrements each cycle and exits to DONE at 0.
REQ-027 DONE: mem_en = 0; the owner's ack = 1 for exactly this one cycle; last_owner updated; then go to IDLE.
REQ-028 DONE, data owner: lock_pending set to data_lock.
REQ-029 Latency: request sampled at edge k -> mem_en high for cycles k+1..k+1+WAIT_CYC -> ack high in cycle k+2+WAIT_CYC.
REQ-030 Minimum spacing: one IDLE cycle between consecutive grants.
REQ-031 Request dropped during ACCESS: the access still completes and the ack is still issued.
REQ-032 data_we and data_addr changes after grant have no effect until the next grant.
REQ-033 mem_address holds its value when not in a data ACCESS; mem_pc_data and mem_w_rd are 0 outside ACCESS.

Reset
REQ-034 rst = 1 forces, asynchronously: state IDLE; mem_en, mem_pc_data, mem_w_rd, fetch_ack, data_ack, busy, lock_pending = 0; mem_address = 16'h0000; last_owner = DATA, so fetch wins the first contention.
REQ-035 Reset asserted mid-ACCESS aborts the access with no ack; after release, arbitration restarts from IDLE on the first clk_2 edge.

Verification
REQ-036 WAIT_CYC=0; fetch_req only -> mem_en=1, mem_pc_data=1 for 1 cycle; fetch_ack pulse in the next cycle; busy=1 for 2 cycles.
REQ-037 WAIT_CYC=2; data_req=1, data_we=1, data_addr=16'h01FF -> mem_en=1, mem_w_rd=1, mem_address=16'h01FF for 3 cycles; then one data_ack pulse.
REQ-038 Both requests held high continuously after reset -> grant order fetch, data, fetch, data; every ack is a single cycle.
REQ-039 Data access with data_lock=1 in DONE, then both requests high -> data granted again; the following contention goes to fetch.
REQ-040 rst pulsed during the second ACCESS cycle with WAIT_CYC=3 -> all outputs 0 immediately, no ack; the held request is regranted after release.
